// File: rtl/i2s_tx_param_if.sv
// Stereo sample handshake between the decoded-sample path and i2s_tx_param.
// The master drives the sample pair; the slave (transmitter) reports ready.
interface i2s_tx_param_if #(
    parameter int SAMPLE_W = 16
);
    logic                s_valid;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;
    logic                s_ready;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface

// File: rtl/i2s_tx_param.sv
// Parametrised I2S / left-justified transmitter with a one-entry sample buffer.
// Optional macro I2S_TX_HOLD_ON_UNDERRUN_EN: underrun frames repeat the last pair.
module i2s_tx_param #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 16,
    parameter int FORMAT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          strobe_i,
    input  logic          en_i,
    i2s_tx_param_if.slave s_if,
    output logic          frame_start_o,
    output logic          underrun_o,
    output logic          lrclk_o,
    output logic          data_o
);
    localparam int FW = 2 * SLOT_W;
    localparam int CW = $clog2(FW);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [FW-1:0]       sh_q, sh_d;
    logic                lrclk_q, lrclk_d;
    logic                data_q, data_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                fs_q, fs_d;
    logic                ur_q, ur_d;
    logic [FW-1:0]       frame_w;
    logic [FW-1:0]       fill_w;
    logic                load_w;
    logic                accept_w;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
    logic [FW-1:0]       last_q, last_d;
`endif

    assign s_if.s_ready  = !full_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;
    assign lrclk_o       = lrclk_q;
    assign data_o        = data_q;

    assign accept_w = s_if.s_valid && !full_q;
    assign load_w   = en_i && strobe_i && (cnt_q == '0);

    // Each sample sits MSB-aligned in its slot; the tail of the slot is zero.
    assign frame_w = (FW'(left_q) << (FW - SAMPLE_W))
                   | (FW'(right_q) << (SLOT_W - SAMPLE_W));

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
    assign fill_w = full_q ? frame_w : last_q;
`else
    assign fill_w = full_q ? frame_w : '0;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        lrclk_d = lrclk_q;
        data_d  = data_q;
        full_d  = full_q;
        left_d  = left_q;
        right_d = right_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        last_d  = last_q;
`endif
        if (accept_w) begin
            full_d  = 1'b1;
            left_d  = s_if.s_left;
            right_d = s_if.s_right;
        end
        if (!en_i) begin
            cnt_d   = '0;
            sh_d    = '0;
            lrclk_d = 1'b1;
            data_d  = 1'b0;
        end else if (strobe_i) begin
            lrclk_d = (cnt_q >= CW'(SLOT_W));
            cnt_d   = (cnt_q == CW'(FW - 1)) ? '0 : cnt_q + 1'b1;
            if (FORMAT == 0) begin
                data_d = sh_q[FW-1];
                sh_d   = load_w ? fill_w : (sh_q << 1);
            end else begin
                data_d = load_w ? fill_w[FW-1] : sh_q[FW-1];
                sh_d   = load_w ? (fill_w << 1) : (sh_q << 1);
            end
            if (load_w) begin
                fs_d = 1'b1;
                ur_d = !full_q;
                // A same-cycle accept into an empty buffer waits a frame.
                if (full_q) full_d = 1'b0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
                if (full_q) last_d = frame_w;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            lrclk_q <= 1'b1;
            data_q  <= 1'b0;
            full_q  <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            last_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            lrclk_q <= lrclk_d;
            data_q  <= data_d;
            full_q  <= full_d;
            left_q  <= left_d;
            right_q <= right_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            last_q  <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_i2s_tx_param.sv
// Directed bench for i2s_tx_param: I2S 16/16 instance and left-justified 24/32.
// Underrun-frame expectations follow I2S_TX_HOLD_ON_UNDERRUN_EN when defined.
module tb_i2s_tx_param;
    logic clk = 1'b0;
    logic rst;
    logic strobe;
    logic en0;
    logic en1;
    logic fs0, ur0, lr0, d0;
    logic fs1, ur1, lr1, d1;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] nl, nr;
    logic [31:0] v;

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
    localparam logic [31:0] UR_EXP = 32'hBEEF0001;
`else
    localparam logic [31:0] UR_EXP = 32'h00000000;
`endif

    always #5 clk = ~clk;

    i2s_tx_param_if #(.SAMPLE_W(16)) if0 ();
    i2s_tx_param_if #(.SAMPLE_W(24)) if1 ();

    i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(16), .FORMAT(0)) u0 (
        .clk(clk), .rst(rst), .strobe_i(strobe), .en_i(en0),
        .s_if(if0.slave), .frame_start_o(fs0), .underrun_o(ur0),
        .lrclk_o(lr0), .data_o(d0)
    );

    i2s_tx_param #(.SAMPLE_W(24), .SLOT_W(32), .FORMAT(1)) u1 (
        .clk(clk), .rst(rst), .strobe_i(strobe), .en_i(en1),
        .s_if(if1.slave), .frame_start_o(fs1), .underrun_o(ur1),
        .lrclk_o(lr1), .data_o(d1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit-clock strobe every 4 clk; optional push on the strobe cycle.
    task automatic tick(input bit push);
        repeat (3) @(negedge clk);
        strobe = 1'b1;
        if (push) begin
            if0.s_valid = 1'b1;
            if0.s_left  = nl;
            if0.s_right = nr;
        end
        @(posedge clk);
        #1;
        strobe = 1'b0;
        if (push) if0.s_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit push_last,
                           output logic [31:0] vv);
        vv = '0;
        for (int i = 0; i < n; i++) begin
            tick(push_last && (i == n - 1));
            vv = {vv[30:0], d0};
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        if0.s_valid = 1'b1;
        if0.s_left  = l;
        if0.s_right = r;
        for (int i = 0; i < 8 && !if0.s_ready; i++) @(negedge clk);
        chk("push_ready", if0.s_ready, 1);
        @(posedge clk);
        #1;
        if0.s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; strobe = 1'b0;
        if0.s_valid = 1'b0; if0.s_left = '0; if0.s_right = '0;
        if1.s_valid = 1'b0; if1.s_left = '0; if1.s_right = '0;
        nl = '0; nr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lrclk", lr0, 1);
        chk("rst_data", d0, 0);
        chk("rst_ready", if0.s_ready, 1);
        chk("rst_fs", fs0, 0);
        chk("rst_ur", ur0, 0);
        @(negedge clk);
        rst = 1'b0;
        en0 = 1'b1;

        push(16'hA5C3, 16'h0FF0);
        chk("full_ready", if0.s_ready, 0);
        @(negedge clk);
        if0.s_valid = 1'b1;
        if0.s_left  = 16'h1234;
        if0.s_right = 16'h5678;
        repeat (2) @(negedge clk);
        chk("held_ready", if0.s_ready, 0);

        tick(0);
        chk("s1_lrclk", lr0, 0);
        chk("s1_fs", fs0, 1);
        chk("s1_ur", ur0, 0);
        chk("s1_ready", if0.s_ready, 1);
        @(posedge clk);
        #1;
        chk("accept_after_load", if0.s_ready, 0);
        @(negedge clk);
        if0.s_left  = 16'hBEEF;
        if0.s_right = 16'h0001;

        collect(16, 0, v);
        chk("s17_lrclk", lr0, 1);
        chk("frame1_left", v[15:0], 16'hA5C3);
        collect(16, 0, v);
        chk("frame1_right", v[15:0], 16'h0FF0);
        chk("s33_fs", fs0, 1);
        chk("s33_ur", ur0, 0);
        @(posedge clk);
        #1;
        chk("p3_accept", if0.s_ready, 0);
        @(negedge clk);
        if0.s_valid = 1'b0;

        collect(32, 0, v);
        chk("frame2", v, 32'h12345678);
        chk("s65_fs", fs0, 1);
        chk("s65_ur", ur0, 0);
        collect(32, 0, v);
        chk("frame3", v, 32'hBEEF0001);
        chk("s97_ur", ur0, 1);
        chk("s97_fs", fs0, 1);

        nl = 16'hC001;
        nr = 16'h7FFE;
        collect(32, 1, v);
        chk("ur_frame_a", v, UR_EXP);
        chk("coinc_ur", ur0, 1);
        chk("coinc_accept", if0.s_ready, 0);
        collect(32, 0, v);
        chk("ur_frame_b", v, UR_EXP);
        chk("s161_fs", fs0, 1);
        chk("s161_ur", ur0, 0);
        push(16'hFFFF, 16'hFFFF);
        collect(32, 0, v);
        chk("coinc_frame", v, 32'hC0017FFE);
        chk("s193_ur", ur0, 0);

        collect(6, 0, v);
        chk("mid_bits", v[5:0], 6'h3F);
        chk("mid_lrclk", lr0, 0);
        @(negedge clk);
        en0 = 1'b0;
        @(posedge clk);
        #1;
        chk("en_off_lrclk", lr0, 1);
        chk("en_off_data", d0, 0);
        push(16'h8001, 16'h4002);
        chk("en_off_buffered", if0.s_ready, 0);
        tick(0);
        tick(0);
        chk("en_off_strobe_lr", lr0, 1);
        chk("en_off_strobe_d", d0, 0);
        chk("en_off_strobe_fs", fs0, 0);
        @(negedge clk);
        en0 = 1'b1;
        tick(0);
        chk("reen_fs", fs0, 1);
        chk("reen_ur", ur0, 0);
        chk("reen_lrclk", lr0, 0);
        collect(32, 0, v);
        chk("reen_frame", v, 32'h80014002);
        chk("reen_next_ur", ur0, 1);

        push(16'h1111, 16'h2222);
        collect(6, 0, v);
        chk("pre_rst_lrclk", lr0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_lrclk", lr0, 1);
        chk("rst_async_data", d0, 0);
        chk("rst_async_ready", if0.s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick(0);
        chk("post_rst_fs", fs0, 1);
        chk("post_rst_ur", ur0, 1);
        push(16'h0F0F, 16'hF0F0);
        collect(32, 0, v);
        chk("post_rst_ur_frame", v, 32'h0);
        chk("post_rst_load_ur", ur0, 0);
        chk("post_rst_load_fs", fs0, 1);
        collect(32, 0, v);
        chk("post_rst_frame", v, 32'h0F0FF0F0);

        @(negedge clk);
        chk("lj_ready", if1.s_ready, 1);
        if1.s_valid = 1'b1;
        if1.s_left  = 24'h800001;
        if1.s_right = 24'h123456;
        @(posedge clk);
        #1;
        if1.s_valid = 1'b0;
        @(negedge clk);
        en1 = 1'b1;
        tick(0);
        chk("lj_lrclk_fall", lr1, 0);
        chk("lj_first_bit", d1, 1);
        chk("lj_fs", fs1, 1);
        chk("lj_ur", ur1, 0);
        v = '0;
        for (int i = 0; i < 31; i++) begin
            tick(0);
            v = {v[30:0], d1};
        end
        chk("lj_left_rest", v[30:0], 31'h100);
        tick(0);
        chk("lj_lrclk_rise", lr1, 1);
        v = {31'b0, d1};
        for (int i = 0; i < 31; i++) begin
            tick(0);
            v = {v[30:0], d1};
        end
        chk("lj_right", v, 32'h12345600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_tx_param.md
Name: i2s_tx_param

Overview:
- Parametrised I2S / left-justified serial audio transmitter; successor to the fixed 16-bit I2S transmitter.
- Sits between the decoded-sample path and the DAC pins.
- Bit timing comes from an external one-cycle `strobe` (one strobe per bit clock).
- Stereo samples are accepted through a valid/ready handshake into a one-entry holding buffer.
- Configurable sample width, slot width and justification; reports underruns.

Parameters:
- SAMPLE_W, 16, bits per channel sample (8..32).
- SLOT_W, 16, bit clocks per channel slot (SAMPLE_W..32); frame = 2*SLOT_W strobes.
- FORMAT, 0, 0 = I2S (data one bit clock after LRCLK edge), 1 = left-justified (data aligned to LRCLK edge).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- strobe  in  1  bit-clock tick; one-cycle pulse; all serial state advances only when high.
- en  in  1  transmit enable; sampled each cycle.
- s_valid  in  1  sample pair valid.
- s_left  in  SAMPLE_W  left sample, two's complement, MSB first on the wire.
- s_right  in  SAMPLE_W  right sample.
- s_ready  out  1  holding buffer empty; transfer on s_valid && s_ready.
- frame_start  out  1  one-cycle pulse on each frame load.
- underrun  out  1  one-cycle pulse when a frame loads with the buffer empty.
- lrclk  out  1  word select (0 = left slot, 1 = right slot).
- data  out  1  serial data.

Behaviour:
- Reset / idle values: lrclk=1, data=0, s_ready=1, frame_start=0, underrun=0, bit counter=0, shifter=0, buffer empty.
- Clock and reset: one clock; reset is asynchronous and active-high; reset is deasserted synchronously to clk upstream.
- Reset asserted mid-frame: aborts immediately; the buffered sample is discarded.
- en low: counter, shifter, lrclk and data are forced to idle values on the next clk edge, regardless of strobe.
  - Buffer and handshake remain operational.
  - en rising: the next strobe is the first load point.
- Bit counter:
  - cnt ranges 0..2*SLOT_W-1.
  - Increments on each strobe while en=1; wraps from 2*SLOT_W-1 to 0.
- LRCLK: on each strobe, lrclk <= (cnt >= SLOT_W), using the pre-increment cnt. lrclk therefore falls on the load strobe.
- Load point is the strobe with cnt==0. On that strobe:
  - Buffer full: the shifter loads {left, zero-pad to SLOT_W, right, zero-pad to SLOT_W}; the buffer empties; frame_start pulses.
  - Buffer empty: the shifter loads all zeros (see Optional Feature); underrun and frame_start both pulse.
- Shifting: on each other strobe, the shifter shifts left by one and zero-fills.
- Data output:
  - FORMAT=0: data <= shifter MSB before the shift, so L[MSB] appears after strobe F+1, where F is the strobe on which lrclk falls.
  - FORMAT=1: on the load strobe, data <= new left MSB; after that, data <= the next bit, so L[MSB] appears after strobe F.
  - Bits beyond SAMPLE_W within a slot are 0.
- Handshake:
  - s_ready = !buffer_full (combinational from the flag).
  - An accept in the same cycle as a load strobe with an empty buffer does not bypass: underrun is flagged and the accepted sample waits for the next frame.
  - s_valid with s_ready=0 holds; no data is lost.
- No latency constraint on the host beyond one accept per frame.

Optional Feature:
- Macro I2S_TX_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, the shifter reloads the last successfully loaded sample pair (zeros if none since reset). The underrun pulse is unchanged.
- Undefined: underrun frames transmit all zeros.

Test Plan:
- Default parameters, strobe every 4 clk. Push L=16'hA5C3, R=16'h0FF0 before the first strobe. Expected:
  - lrclk falls on strobe 1.
  - data after strobes 2..17 = 1010010111000011.
  - lrclk rises on strobe 17; data after strobes 18..33 = 0000111111110000.
  - frame_start on strobe 1; no underrun.
- FORMAT=1, SAMPLE_W=24, SLOT_W=32, L=24'h800001 -> data = 1 after the lrclk-falling strobe, then 22 zeros, then 1, then 8 zeros; right slot starts on the lrclk-rising strobe.
- No sample pushed -> underrun pulse at every load strobe and data constant 0. Repeat with I2S_TX_HOLD_ON_UNDERRUN_EN after one pushed pair 16'h1234/16'h5678 -> that pair repeats on the wire every frame.
- Push while the buffer is full -> s_ready=0, s_valid held. Accepted on the cycle after the load strobe. Value order preserved across 3 back-to-back frames.
- Accept coincident with the load strobe and the buffer empty -> underrun=1 on that cycle; the sample is transmitted in the following frame.
- Assert rst (or drop en) at cnt=7 mid-left-slot -> lrclk=1 and data=0 immediately (rst) or on the next clk (en). After release/re-enable the next strobe is a clean load point and the first frame is correct.
